// File: rtl/wbgpio_irq.sv
// Wishbone GPIO port with per-pin edge-select, sticky W1C pending flags and a masked interrupt.
// Define WBGPIO_IRQ_DEBOUNCE_EN to insert a per-pin debounce filter after the synchroniser.
module wbgpio_irq #(
    parameter int              NIN         = 16,
    parameter int              NOUT        = 16,
    parameter logic [NOUT-1:0] DEFAULT     = '0,
    parameter int              SYNC_STAGES = 2,
    parameter int              DEBOUNCE    = 15
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [1:0]      i_wb_addr,
    input  logic [31:0]     i_wb_data,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic [31:0]     o_wb_data,
    input  logic [NIN-1:0]  i_gpio,
    output logic [NOUT-1:0] o_gpio,
    output logic            o_int
);

    if (NIN < 1 || NIN > 16 || NOUT < 1 || NOUT > 16 || SYNC_STAGES < 2 || DEBOUNCE < 1) begin : g_bad_param
        $error("wbgpio_irq: parameter out of range");
    end

    // Handshake: a request (cyc & stb) is always accepted in the cycle it is presented
    // (stall is tied low) and answered by a one-cycle ack on the next clock, with read data
    // registered alongside the ack.
    logic acc, wr;
    assign acc        = i_wb_cyc & i_wb_stb;
    assign wr         = acc & i_wb_we;
    assign o_wb_stall = 1'b0;

    logic [NIN-1:0] sync_q [SYNC_STAGES];
    logic [NIN-1:0] s, filt, prev_q;
    logic [NIN-1:0] edge_r_q, edge_f_q, pend_q, mask_q;
    logic [NIN-1:0] rise, fall, evt, clr;
    logic [31:0]    rdata;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= i_gpio;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef WBGPIO_IRQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE + 1);
    logic [CW-1:0]  cnt_q [NIN];
    logic [NIN-1:0] filt_q;

    // A pin's filtered value follows s only after DEBOUNCE consecutive differing cycles.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            filt_q <= '0;
            for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (s[i] == filt_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
                    filt_q[i] <= s[i];
                    cnt_q[i]  <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end
    assign filt = filt_q;
`else
    assign filt = s;
`endif

    assign rise = filt & ~prev_q;
    assign fall = ~filt & prev_q;
    assign evt  = (rise & edge_r_q) | (fall & edge_f_q);
    assign clr  = (wr && i_wb_addr == 2'd2) ? i_wb_data[NIN-1:0] : '0;

    always_comb begin
        rdata = '0;
        case (i_wb_addr)
            2'd0: begin
                rdata[NOUT-1:0]   = o_gpio;
                rdata[NIN+15:16]  = filt;
            end
            2'd1: begin
                rdata[NIN+15:16]  = edge_r_q;
                rdata[NIN-1:0]    = edge_f_q;
            end
            2'd2:    rdata[NIN-1:0] = pend_q;
            default: rdata[NIN-1:0] = mask_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_gpio    <= DEFAULT;
            edge_r_q  <= '0;
            edge_f_q  <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            prev_q    <= '0;
            o_int     <= 1'b0;
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= acc;
            if (acc) o_wb_data <= rdata;
            if (wr) begin
                case (i_wb_addr)
                    2'd0: o_gpio <= (o_gpio & ~i_wb_data[NOUT+15:16])
                                  | (i_wb_data[NOUT-1:0] & i_wb_data[NOUT+15:16]);
                    2'd1: begin
                        edge_r_q <= i_wb_data[NIN+15:16];
                        edge_f_q <= i_wb_data[NIN-1:0];
                    end
                    2'd3:    mask_q <= i_wb_data[NIN-1:0];
                    default: ;
                endcase
            end
            prev_q <= filt;
            // Set wins over a simultaneous write-1-to-clear of the same bit.
            pend_q <= (pend_q & ~clr) | evt;
            o_int  <= |(pend_q & mask_q);
        end
    end

endmodule

// File: tb/tb_wbgpio_irq.sv
// Self-checking bench for wbgpio_irq: register table, edge/pending/interrupt sequences, reset cases.
module tb_wbgpio_irq;
    localparam int NIN = 16;
    localparam int NOUT = 16;
    localparam int SYNC = 2;
    localparam logic [15:0] DEF = 16'h00A5;
`ifdef WBGPIO_IRQ_DEBOUNCE_EN
    localparam int DB = 15;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = SYNC + 2 + DB;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
    logic [1:0]  i_wb_addr = '0;
    logic [31:0] i_wb_data = '0;
    logic        o_wb_stall, o_wb_ack, o_int;
    logic [31:0] o_wb_data;
    logic [15:0] i_gpio = '0;
    logic [15:0] o_gpio;

    int tests = 0;
    int failed = 0;
    logic [31:0] exp_q[$];

    wbgpio_irq #(.NIN(NIN), .NOUT(NOUT), .DEFAULT(DEF), .SYNC_STAGES(SYNC), .DEBOUNCE(15)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
        .i_gpio(i_gpio), .o_gpio(o_gpio), .o_int(o_int)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle; ack must be present exactly one clock after the access.
    task automatic bus_op(input logic [1:0] a, input logic we, input logic [31:0] d, output logic [31:0] q);
        @(negedge i_clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we; i_wb_addr = a; i_wb_data = d;
        @(negedge i_clk);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        check("ack", {31'b0, o_wb_ack}, 32'd1);
        check("stall", {31'b0, o_wb_stall}, 32'd0);
        q = o_wb_data;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus_op(a, 1'b1, d, q);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] q;
        exp_q.push_back(exp);
        bus_op(a, 1'b0, 32'h0, q);
        if (exp_q.size() == 0) check("scoreboard_empty", 32'd0, 32'd1);
        else check("rdata", q, exp_q.pop_front());
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [15:0] exp_gpio;
    } vec_t;

    vec_t vec[16];

    initial begin
        vec[0]  = '{2'd0, 1'b0, 32'h0,          32'h0002_00A5, 16'h00A5};
        vec[1]  = '{2'd1, 1'b0, 32'h0,          32'h0,         16'h00A5};
        vec[2]  = '{2'd2, 1'b0, 32'h0,          32'h0,         16'h00A5};
        vec[3]  = '{2'd3, 1'b0, 32'h0,          32'h0,         16'h00A5};
        vec[4]  = '{2'd0, 1'b1, 32'h0003_0001,  32'h0,         16'h00A5};
        vec[5]  = '{2'd0, 1'b1, 32'h0003_0002,  32'h0,         16'h00A6};
        vec[6]  = '{2'd0, 1'b0, 32'h0,          32'h0002_00A6, 16'h00A6};
        vec[7]  = '{2'd1, 1'b1, 32'hFFFF_FFFF,  32'h0,         16'h00A6};
        vec[8]  = '{2'd1, 1'b0, 32'h0,          32'hFFFF_FFFF, 16'h00A6};
        vec[9]  = '{2'd1, 1'b1, 32'h0001_0000,  32'h0,         16'h00A6};
        vec[10] = '{2'd1, 1'b0, 32'h0,          32'h0001_0000, 16'h00A6};
        vec[11] = '{2'd3, 1'b1, 32'hFFFF_0001,  32'h0,         16'h00A6};
        vec[12] = '{2'd3, 1'b0, 32'h0,          32'h0000_0001, 16'h00A6};
        vec[13] = '{2'd0, 1'b1, 32'hFF00_FFFF,  32'h0,         16'hFFA6};
        vec[14] = '{2'd0, 1'b0, 32'h0,          32'h0002_FFA6, 16'hFFA6};
        vec[15] = '{2'd2, 1'b0, 32'h0,          32'h0,         16'hFFA6};

        // Reset with pin 1 already high: that edge must never reach PEND.
        i_gpio = 16'h0002;
        i_reset_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_int", {31'b0, o_int}, 32'd0);
        check("rst_ack", {31'b0, o_wb_ack}, 32'd0);
        check("rst_data", o_wb_data, 32'd0);
        check("rst_gpio", {16'b0, o_gpio}, {16'b0, DEF});
        i_reset_n = 1'b1;
        repeat (LAT + 5) @(negedge i_clk);

        for (int i = 0; i < 16; i++) begin
            if (vec[i].we) wr(vec[i].addr, vec[i].wdata);
            else rd(vec[i].addr, vec[i].exp_rd);
            check("gpio", {16'b0, o_gpio}, {16'b0, vec[i].exp_gpio});
        end
        check("int_idle", {31'b0, o_int}, 32'd0);

        // Rising edge on pin 0 (EDGE rise0, MASK=1): o_int exactly LAT cycles after the pin change.
        @(negedge i_clk);
        i_gpio[0] = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge i_clk);
            check("int_latency", {31'b0, o_int}, (k == LAT) ? 32'd1 : 32'd0);
        end
        rd(2'd2, 32'h1);
        wr(2'd2, 32'h1);
        rd(2'd2, 32'h0);
        i_gpio[0] = 1'b0;
        repeat (LAT + 2) @(negedge i_clk);
        rd(2'd2, 32'h0);
        check("fall_no_int", {31'b0, o_int}, 32'd0);

        // W1C landing in the same cycle as a new event: set wins.
        i_gpio[0] = 1'b1;
        repeat (LAT + 1) @(negedge i_clk);
        rd(2'd2, 32'h1);
        check("int_set", {31'b0, o_int}, 32'd1);
        i_gpio[0] = 1'b0;
        repeat (LAT + 2) @(negedge i_clk);
        i_gpio[0] = 1'b1;
        repeat (SYNC - 1 + DB) @(negedge i_clk);
        wr(2'd2, 32'h1);
        check("setwin_int", {31'b0, o_int}, 32'd1);
        rd(2'd2, 32'h1);
        check("setwin_int2", {31'b0, o_int}, 32'd1);
        wr(2'd2, 32'h1);
        check("clr_int_hold", {31'b0, o_int}, 32'd1);
        @(negedge i_clk);
        check("clr_int_drop", {31'b0, o_int}, 32'd0);
        rd(2'd2, 32'h0);

        // Both edges on pin 3, masked off; then unmask and mask again.
        wr(2'd1, 32'h0008_0008);
        wr(2'd3, 32'h0);
        i_gpio[3] = 1'b1;
        repeat (LAT + 2) @(negedge i_clk);
        rd(2'd2, 32'h8);
        i_gpio[3] = 1'b0;
        repeat (LAT + 2) @(negedge i_clk);
        rd(2'd2, 32'h8);
        check("masked_int", {31'b0, o_int}, 32'd0);
        rd(2'd0, 32'h0003_FFA6);
        wr(2'd3, 32'h8);
        check("unmask_int0", {31'b0, o_int}, 32'd0);
        @(negedge i_clk);
        check("unmask_int1", {31'b0, o_int}, 32'd1);
        wr(2'd3, 32'h0);
        @(negedge i_clk);
        check("remask_int", {31'b0, o_int}, 32'd0);
        rd(2'd2, 32'h8);

`ifdef WBGPIO_IRQ_DEBOUNCE_EN
        wr(2'd1, 32'h0004_0004);
        wr(2'd2, 32'hFFFF);
        i_gpio[2] = 1'b1;
        repeat (10) @(negedge i_clk);
        i_gpio[2] = 1'b0;
        repeat (25) @(negedge i_clk);
        rd(2'd0, 32'h0003_FFA6);
        rd(2'd2, 32'h0);
        i_gpio[2] = 1'b1;
        repeat (20) @(negedge i_clk);
        rd(2'd0, 32'h0007_FFA6);
        rd(2'd2, 32'h4);
        i_gpio[2] = 1'b0;
`endif

        // Reset in the middle of an acked cycle drops ack at once.
        i_gpio = '0;
        repeat (LAT + 2) @(negedge i_clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 2'd0;
        @(posedge i_clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("midrst_ack", {31'b0, o_wb_ack}, 32'd0);
        check("midrst_data", o_wb_data, 32'd0);
        check("midrst_gpio", {16'b0, o_gpio}, {16'b0, DEF});
        @(negedge i_clk);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        i_reset_n = 1'b1;
        repeat (3) @(negedge i_clk);
        rd(2'd0, 32'h0000_00A5);
        rd(2'd1, 32'h0);
        rd(2'd2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
